mac6_seq_ctrl: RTL and testbench
================================

Name: mac6_seq_ctrl

Overview:
Sequencer for one 6-lane multiply-accumulate PE. It accepts a dot-product job (length, base address) and issues chunk reads of 6 feature/weight pairs from the PE-local buffers. It drives the MAC accumulate select and lane enables, waits out the pipeline latency, then returns the final sum through a valid/ready result port. It sits between the PE scheduler and a single MAC_6-style datapath.

Parameters:
PE_OUT_WIDTH, 16, width of MAC sum and result
LEN_WIDTH, 10, width of job length (elements)
ADDR_WIDTH, 8, width of chunk read address
PERF_WIDTH, 32, width of performance counters (optional feature only)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  job request; accepted only in IDLE
len  input  LEN_WIDTH  number of elements in job; sampled on accept
base_addr  input  ADDR_WIDTH  chunk address of first 6-element chunk; sampled on accept
busy  output  1  high in every state except IDLE
rd_en  output  1  buffer read strobe, one chunk per cycle
rd_addr  output  ADDR_WIDTH  chunk address = base_addr + k
mac_acc  output  1  MAC accumulate select, aligned with buffer data (1 cycle after rd_en)
mac_lane_en  output  6  per-lane enable; datapath zeroes disabled lanes; aligned with mac_acc
mac_sum  input  PE_OUT_WIDTH  registered sum from MAC
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
res_data  output  PE_OUT_WIDTH  final dot product, held while res_valid

Behaviour:
- Reset (sync, rst=1 at clock edge): state=IDLE; busy, rd_en, mac_acc, res_valid = 0; mac_lane_en=0; rd_addr=0; res_data=0; chunk counter=0. Reset mid-job aborts it immediately. No result is produced.
- N = ceil(len/6) chunks. Last-chunk remainder r = len - 6*(N-1), in 1..6.
- Buffer read latency: 1 cycle. MAC latency: 1 cycle (registered sum).
- States:
  - IDLE: start=1 and len>0 -> latch len/base, k=0, go ISSUE. start=1 and len=0 -> res_data=0, go RESULT; no reads issued. start while not IDLE is ignored (no queueing).
  - ISSUE: rd_en=1, rd_addr=base+k each cycle, k increments. After the cycle with k=N-1, go DRAIN.
  - DRAIN: 2 cycles (data-to-MAC cycle, then MAC register cycle), then capture res_data<=mac_sum and go RESULT.
  - RESULT: res_valid=1. On res_valid&res_ready go IDLE. start is accepted again the cycle after.
- Alignment: for the chunk read at cycle t, at cycle t+1 mac_acc = (k!=0) and mac_lane_en = 6'b111111. For the last chunk, mac_lane_en = (1<<r)-1. mac_acc=0 and mac_lane_en=0 whenever no chunk data is on the MAC inputs.
- Single-chunk job (N=1): mac_acc=0 on its only data cycle.
- Latency: start accepted at cycle 0 -> first rd_en cycle 1 -> res_valid at cycle N+3.
- Arithmetic: wrap-around is owned by the datapath; res_data is mac_sum unmodified. rd_addr wraps modulo 2^ADDR_WIDTH.
- Backpressure: res_data and res_valid are stable until handshake; no new reads while in RESULT.

Optional Feature:
MAC6_CTRL_PERF_EN: when defined, adds outputs perf_jobs and perf_busy_cycles (PERF_WIDTH each).
- perf_jobs increments on each completed result handshake.
- perf_busy_cycles increments every cycle busy=1.
- Both clear on rst and saturate at all-ones.
When undefined: the ports and counters do not exist, and the remaining behaviour is identical.

Test Plan:
- len=6, base=4, all a=1, b=2 -> one rd_en at addr 4; mac_acc=0, lane_en=6'h3F; res_valid at cycle 4 with res_data=12.
- len=14, base=0, a=1, b=1 -> rd_addr 0,1,2; mac_acc 0,1,1; last lane_en=6'b000011; res_data=14 at cycle 6.
- len=0 -> no rd_en; res_valid the cycle after accept with res_data=0.
- len=12 with res_ready held low 5 cycles -> res_valid and res_data stable; start pulses during this are ignored; accepted after handshake.
- rst asserted during ISSUE of len=30 job -> next cycle all outputs 0, IDLE; a new len=6 job completes correctly.
- With MAC6_CTRL_PERF_EN: run jobs len=6 then len=14 -> perf_jobs=2, perf_busy_cycles=4+6=10.

Source files
------------

// File: rtl/mac6_seq_ctrl.sv
// Job sequencer for a single 6-lane MAC PE: issues chunk reads, steers the MAC, returns the sum.
// Optional performance counters are compiled in when MAC6_CTRL_PERF_EN is defined.
module mac6_seq_ctrl #(
  parameter int PE_OUT_WIDTH = 16,
  parameter int LEN_WIDTH    = 10,
  parameter int ADDR_WIDTH   = 8
`ifdef MAC6_CTRL_PERF_EN
  ,
  parameter int PERF_WIDTH   = 32
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN_WIDTH-1:0]    len,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  output logic                    busy,
  output logic                    rd_en,
  output logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic                    mac_acc,
  output logic [5:0]              mac_lane_en,
  input  logic [PE_OUT_WIDTH-1:0] mac_sum,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [PE_OUT_WIDTH-1:0] res_data
`ifdef MAC6_CTRL_PERF_EN
  ,
  output logic [PERF_WIDTH-1:0]   perf_jobs,
  output logic [PERF_WIDTH-1:0]   perf_busy_cycles
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESULT} state_t;

  localparam logic [LEN_WIDTH-1:0] CHUNK = LEN_WIDTH'(6);

  state_t               state;
  logic [LEN_WIDTH-1:0] remaining;
  logic [LEN_WIDTH-1:0] chunk;
  logic                 drain_second;

  // Lanes holding valid elements for a chunk with 'left' elements still outstanding.
  function automatic logic [5:0] lane_mask(input logic [LEN_WIDTH-1:0] left);
    if (left >= CHUNK) return 6'h3F;
    return (6'd1 << left[2:0]) - 6'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      rd_en        <= 1'b0;
      rd_addr      <= '0;
      mac_acc      <= 1'b0;
      mac_lane_en  <= '0;
      res_valid    <= 1'b0;
      res_data     <= '0;
      remaining    <= '0;
      chunk        <= '0;
      drain_second <= 1'b0;
    end else begin
      mac_acc     <= 1'b0;
      mac_lane_en <= '0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (len != '0) begin
              remaining <= len;
              chunk     <= '0;
              rd_en     <= 1'b1;
              rd_addr   <= base_addr;
              state     <= ISSUE;
            end else begin
              res_data  <= '0;
              res_valid <= 1'b1;
              state     <= RESULT;
            end
          end
        end
        ISSUE: begin
          // Buffer data for this read arrives next cycle, so steer the MAC for it now.
          mac_acc     <= (chunk != '0);
          mac_lane_en <= lane_mask(remaining);
          if (remaining <= CHUNK) begin
            rd_en        <= 1'b0;
            drain_second <= 1'b0;
            state        <= DRAIN;
          end else begin
            remaining <= remaining - CHUNK;
            chunk     <= chunk + LEN_WIDTH'(1);
            rd_addr   <= rd_addr + ADDR_WIDTH'(1);
          end
        end
        DRAIN: begin
          if (!drain_second) begin
            drain_second <= 1'b1;
          end else begin
            res_data  <= mac_sum;
            res_valid <= 1'b1;
            state     <= RESULT;
          end
        end
        RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MAC6_CTRL_PERF_EN
  function automatic logic [PERF_WIDTH-1:0] sat_inc(input logic [PERF_WIDTH-1:0] v);
    return (&v) ? v : v + PERF_WIDTH'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_jobs        <= '0;
      perf_busy_cycles <= '0;
    end else begin
      if (res_valid && res_ready) perf_jobs <= sat_inc(perf_jobs);
      if (busy) perf_busy_cycles <= sat_inc(perf_busy_cycles);
    end
  end
`endif

endmodule

// File: tb/tb_mac6_seq_ctrl.sv
// Scoreboard bench for mac6_seq_ctrl: a buffer+MAC model feeds mac_sum, a monitor checks every cycle.
// Build with MAC6_CTRL_PERF_EN defined to also check the performance counters.
module tb_mac6_seq_ctrl;
  localparam int PW = 16;
  localparam int LW = 10;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] len;
  logic [AW-1:0] base_addr;
  logic          busy, rd_en, mac_acc, res_valid, res_ready;
  logic [AW-1:0] rd_addr;
  logic [5:0]    mac_lane_en;
  logic [PW-1:0] mac_sum = '0;
  logic [PW-1:0] res_data;
`ifdef MAC6_CTRL_PERF_EN
  logic [31:0]   perf_jobs, perf_busy_cycles;
`endif

  always #5 clk = ~clk;

  mac6_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .base_addr(base_addr),
    .busy(busy), .rd_en(rd_en), .rd_addr(rd_addr), .mac_acc(mac_acc),
    .mac_lane_en(mac_lane_en), .mac_sum(mac_sum), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data)
`ifdef MAC6_CTRL_PERF_EN
    , .perf_jobs(perf_jobs), .perf_busy_cycles(perf_busy_cycles)
`endif
  );

  logic [7:0] fa [256][6];
  logic [7:0] wb [256][6];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_seen = 1'b0;
  always @(posedge clk) rst_seen <= rst;

  int checks = 0;
  int errors = 0;

  typedef struct { int cyc; logic [PW-1:0] data; } res_t;
  typedef struct { int cyc; logic [AW-1:0] addr; } rd_t;
  typedef struct { int cyc; logic acc; logic [5:0] lanes; } mc_t;
  res_t sbq[$];
  rd_t  rdq[$];
  mc_t  mcq[$];

  int tmo_cnt = 0;
  bit done = 1'b0;
`ifdef MAC6_CTRL_PERF_EN
  int pe_jobs = 0, pe_busy = 0, perf_id = 0;
`endif

  // Buffers (1-cycle read) and a registered 6-lane MAC, as the datapath around the sequencer.
  logic [7:0] a_q [6];
  logic [7:0] b_q [6];
  always @(posedge clk) begin : datapath
    logic [PW-1:0] s;
    s = mac_acc ? mac_sum : '0;
    for (int j = 0; j < 6; j++)
      if (mac_lane_en[j]) s = s + ({8'd0, a_q[j]} * {8'd0, b_q[j]});
    mac_sum <= s;
    for (int j = 0; j < 6; j++) begin
      a_q[j] <= rd_en ? fa[rd_addr][j] : 8'($urandom);
      b_q[j] <= rd_en ? wb[rd_addr][j] : 8'($urandom);
    end
  end

  function automatic logic [PW-1:0] ref_dot(input int l, input int b);
    logic [PW-1:0] s = '0;
    for (int i = 0; i < l; i++)
      s = s + ({8'd0, fa[(b + i / 6) % 256][i % 6]} * {8'd0, wb[(b + i / 6) % 256][i % 6]});
    return s;
  endfunction

  function automatic int busy_of(input int l);
    return (l == 0) ? 1 : (l + 5) / 6 + 3;
  endfunction

  task automatic push_job(input int l, input int b, input int c0);
    int n, r;
    res_t e;
    n = (l + 5) / 6;
    e.cyc = c0 + ((l == 0) ? 1 : n + 3);
    e.data = ref_dot(l, b);
    sbq.push_back(e);
    for (int k = 0; k < n; k++) begin
      rd_t ra;
      mc_t ma;
      ra.cyc = c0 + 1 + k;
      ra.addr = AW'((b + k) % 256);
      rdq.push_back(ra);
      r = (k == n - 1) ? l - 6 * k : 6;
      ma.cyc = c0 + 2 + k;
      ma.acc = (k != 0);
      ma.lanes = 6'((1 << r) - 1);
      mcq.push_back(ma);
    end
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: every cycle compares DUT outputs against the queued expectations.
  bit held = 1'b0;
  logic [PW-1:0] hold_data = '0;
  int tmo_rep = 0;
  bit fin = 1'b0;
`ifdef MAC6_CTRL_PERF_EN
  int perf_done = 0;
`endif
  always @(negedge clk) begin : monitor
    if (rst_seen) begin
      sbq.delete(); rdq.delete(); mcq.delete();
      held = 1'b0;
      chk("reset_state", longint'({busy, rd_en, rd_addr, mac_acc, mac_lane_en, res_valid, res_data}), 64'd0);
`ifdef MAC6_CTRL_PERF_EN
      chk("reset_perf", longint'({perf_jobs, perf_busy_cycles}), 64'd0);
`endif
    end else begin
      if (rdq.size() > 0 && rdq[0].cyc == cyc) begin
        rd_t e;
        e = rdq.pop_front();
        chk("rd_en", longint'(rd_en), 64'd1);
        chk("rd_addr", longint'(rd_addr), longint'(e.addr));
      end else begin
        chk("rd_idle", longint'(rd_en), 64'd0);
      end
      if (mcq.size() > 0 && mcq[0].cyc == cyc) begin
        mc_t e;
        e = mcq.pop_front();
        chk("mac_acc", longint'(mac_acc), longint'(e.acc));
        chk("mac_lane_en", longint'(mac_lane_en), longint'(e.lanes));
      end else begin
        chk("mac_idle", longint'({mac_acc, mac_lane_en}), 64'd0);
      end
      if (res_valid && !held) begin
        if (sbq.size() == 0) begin
          chk("res_unexpected", 64'd1, 64'd0);
        end else begin
          res_t e;
          e = sbq.pop_front();
          chk("res_data", longint'(res_data), longint'(e.data));
          chk("res_cycle", longint'(cyc), longint'(e.cyc));
        end
        held = 1'b1;
        hold_data = res_data;
      end else if (held) begin
        chk("res_hold", longint'({res_valid, res_data}), longint'({1'b1, hold_data}));
      end
      if (res_valid && res_ready) held = 1'b0;
    end
    if (tmo_cnt != tmo_rep) begin
      chk("result_timeout", 64'd1, 64'd0);
      tmo_rep = tmo_cnt;
    end
`ifdef MAC6_CTRL_PERF_EN
    if (perf_id != perf_done) begin
      chk("perf_jobs", longint'(perf_jobs), longint'(pe_jobs));
      chk("perf_busy_cycles", longint'(perf_busy_cycles), longint'(pe_busy));
      perf_done = perf_id;
    end
`endif
    if (done && !fin) begin
      fin = 1'b1;
      chk("queues_drained", longint'(sbq.size() + rdq.size() + mcq.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  task automatic fill_rand();
    for (int c = 0; c < 256; c++)
      for (int j = 0; j < 6; j++) begin
        fa[c][j] = 8'($urandom);
        wb[c][j] = 8'($urandom);
      end
  endtask

  task automatic fill(input int b, input int n, input int a, input int w);
    for (int c = 0; c < n; c++)
      for (int j = 0; j < 6; j++) begin
        fa[(b + c) % 256][j] = 8'(a);
        wb[(b + c) % 256][j] = 8'(w);
      end
  endtask

  task automatic run_job(input int l, input int b, input int stall, input bit hold2);
    int t;
    res_ready = (stall == 0);
    @(posedge clk); #1;
    start = 1'b1;
    len = LW'(l);
    base_addr = AW'(b);
    push_job(l, b, cyc);
    if (hold2) begin
      @(posedge clk); #1;
      len = LW'($urandom);
    end
    @(posedge clk); #1;
    start = 1'b0;
    t = 0;
    while (!res_valid && t < 1000) begin
      @(posedge clk); #1;
      t++;
    end
    if (!res_valid) begin
      tmo_cnt++;
      return;
    end
    // Stalled result: stray start pulses must be ignored.
    repeat (stall) begin
      start = 1'($urandom_range(0, 1));
      len = LW'($urandom);
      base_addr = AW'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
`ifdef MAC6_CTRL_PERF_EN
    pe_jobs += 1;
    pe_busy += busy_of(l) + stall;
`endif
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; base_addr = '0; res_ready = 1'b0;
    fill_rand();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    fill(4, 1, 1, 2);
    run_job(6, 4, 0, 1'b0);
    fill(0, 3, 1, 1);
    run_job(14, 0, 0, 1'b0);
`ifdef MAC6_CTRL_PERF_EN
    perf_id++;
`endif
    run_job(0, 17, 0, 1'b0);
    fill_rand();
    run_job(12, 100, 5, 1'b0);

    // Abort a long job with reset while it is still issuing reads.
    res_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; len = LW'(30); base_addr = AW'(200);
    push_job(30, 200, cyc);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
`ifdef MAC6_CTRL_PERF_EN
    pe_jobs = 0;
    pe_busy = 0;
`endif
    run_job(6, 5, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      int l, b, s;
      bit h;
      fill_rand();
      l = (i == 0) ? 1023 : $urandom_range(0, 50);
      b = (i == 0) ? 250 : $urandom_range(0, 255);
      s = $urandom_range(0, 3);
      h = (l != 0) && ($urandom_range(0, 1) == 1);
      run_job(l, b, s, h);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
`ifdef MAC6_CTRL_PERF_EN
    perf_id++;
    @(posedge clk); #1;
`endif
    repeat (3) @(posedge clk);
    #1 done = 1'b1;
  end

endmodule
